mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096, RUN-state cycle limit before abort (used only with MUL_TIMEOUT_EN).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 req  input  3  per-requester multiply request, level, bit k = requester k.
REQ-005 req_a  input  768  operand A; requester k on bits [256k+255:256k].
REQ-006 req_b  input  768  operand B; same packing as req_a.
REQ-007 res_valid  output  1  one-cycle pulse; res/res_id/res_err valid.
REQ-008 res_id  output  2  index of the requester served (0..2).
REQ-009 res  output  512  product A*B.
REQ-010 res_err  output  1  high with res_valid when the operation timed out.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mul_a, mul_b  output  256 each  operands to the shared 256x256 multiplier.
REQ-013 mul_run  output  1  drives the multiplier's active-low reset; low = multiplier cleared, high = computing.
REQ-014 mul_done  input  1  multiplier done level.
REQ-015 mul_c  input  512  multiplier product, valid while mul_done high.

Function
REQ-016 FSM states: IDLE, LOAD, RUN, RESP; IDLE -> LOAD when any req bit high, else stay.
REQ-017 Arbitration: round-robin; search starts at (last_grant+1) mod 3, wraps 2 -> 0; last_grant resets to 2 so requester 0 wins first.
REQ-018 IDLE -> LOAD edge: latch winner index into grant and last_grant.
REQ-019 LOAD (exactly 1 cycle): mul_a/mul_b load the winner's operands, mul_run = 0; -> RUN.
REQ-020 mul_a/mul_b hold stable from LOAD until the next LOAD.
REQ-021 RUN: mul_run = 1; mul_done ignored in the first RUN cycle; on mul_done = 1 capture mul_c into res, -> RESP.
REQ-022 RESP (exactly 1 cycle): res_valid = 1, res_id = grant, mul_run = 0; -> IDLE.
REQ-023 res, res_id, res_err hold their values until the next RESP.
REQ-024 Requester k deasserts req[k] in the cycle after its res_valid; the arbiter samples req only in IDLE, so the next grant is decided one cycle after RESP.
REQ-025 req changes outside IDLE are ignored; a requester dropping req mid-operation still receives its res_valid.
REQ-026 Latency: request seen in IDLE at cycle t -> res_valid at t + 3 + M, where M = RUN cycles until mul_done.
REQ-027 Simultaneous requests: one grant per pass, round-robin order; no requester is starved beyond two other operations.
REQ-028 Products are full 512-bit, unsigned; no truncation or reduction in this block.

Reset
REQ-029 rst high asynchronously forces: state IDLE, mul_run 0, res_valid 0, res_err 0, busy 0, res 0, res_id 0, mul_a 0, mul_b 0, last_grant 2, timeout counter 0.
REQ-030 Reset mid-operation aborts the operation with no res_valid; after release, pending requests are re-arbitrated from requester 0.

Configuration
REQ-031 Macro MUL_TIMEOUT_EN defined: 16-bit counter clears in LOAD and increments in RUN.
REQ-032 With MUL_TIMEOUT_EN, reaching TIMEOUT_CYC in RUN without mul_done forces -> RESP with res = 0 and res_err = 1.
REQ-033 With MUL_TIMEOUT_EN, res_err clears on any RESP without timeout.
REQ-034 MUL_TIMEOUT_EN undefined: no counter; res_err tied 0; RUN waits indefinitely.

Verification
REQ-035 req = 001, A0 = 3, B0 = 5 -> one res_valid, res_id = 0, res = 15, res_err = 0.
REQ-036 req = 111 held, operands A = k+2, B = 7 -> res_valid sequence ids 0, 1, 2, results 14, 21, 28; busy low exactly one cycle between operations.
REQ-037 A = B = 2^256-1 -> res = 2^512 - 2^257 + 1.
REQ-038 Requester 1 re-requests immediately while requester 2 is pending -> grant order 1, 2, 1.
REQ-039 MUL_TIMEOUT_EN, TIMEOUT_CYC = 16, stub multiplier never raises mul_done -> res_valid 16 cycles after RUN entry, res = 0, res_err = 1; the next request completes normally.
REQ-040 rst pulsed during RUN -> all outputs at reset values immediately, no res_valid; held req = 010 is served after release with the correct product.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one 256x256 multiplier between three requesters.
// Optional RUN-state timeout abort is enabled by defining MUL_TIMEOUT_EN.
module mul_arbiter
`ifdef MUL_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYC = 4096)
`endif
(
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [767:0] req_a,
  input  logic [767:0] req_b,
  output logic         res_valid,
  output logic [1:0]   res_id,
  output logic [511:0] res,
  output logic         res_err,
  output logic         busy,
  output logic [255:0] mul_a,
  output logic [255:0] mul_b,
  output logic         mul_run,
  input  logic         mul_done,
  input  logic [511:0] mul_c
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

  state_t       state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic [1:0]   last_grant_q, last_grant_d;
  logic [1:0]   res_id_q, res_id_d;
  logic [255:0] mul_a_q, mul_a_d;
  logic [255:0] mul_b_q, mul_b_d;
  logic [511:0] res_q, res_d;
  logic         res_err_q, res_err_d;
  logic         first_q, first_d;
`ifdef MUL_TIMEOUT_EN
  logic [15:0]  cnt_q, cnt_d;
`endif

  logic [255:0] op_a [3];
  logic [255:0] op_b [3];
  logic [1:0]   cand [3];
  logic [1:0]   winner;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ops
    assign op_a[gi] = req_a[256*gi +: 256];
    assign op_b[gi] = req_b[256*gi +: 256];
  end

  // Candidates in round-robin order starting after the last grant.
  always_comb begin
    cand[0] = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
    cand[1] = (cand[0] == 2'd2) ? 2'd0 : cand[0] + 2'd1;
    cand[2] = (cand[1] == 2'd2) ? 2'd0 : cand[1] + 2'd1;
    winner  = cand[0];
    for (int i = 2; i >= 0; i--) begin
      if (req[cand[i]]) winner = cand[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    res_id_d     = res_id_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    res_d        = res_q;
    res_err_d    = res_err_q;
    first_d      = first_q;
`ifdef MUL_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d      = S_LOAD;
          grant_d      = winner;
          last_grant_d = winner;
          mul_a_d      = op_a[winner];
          mul_b_d      = op_b[winner];
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        first_d = 1'b1;
`ifdef MUL_TIMEOUT_EN
        cnt_d   = 16'd0;
`endif
      end
      S_RUN: begin
        first_d = 1'b0;
`ifdef MUL_TIMEOUT_EN
        cnt_d   = cnt_q + 16'd1;
`endif
        // The multiplier's done level is stale on the first RUN cycle.
        if (!first_q && mul_done) begin
          state_d   = S_RESP;
          res_d     = mul_c;
          res_id_d  = grant_q;
          res_err_d = 1'b0;
        end
`ifdef MUL_TIMEOUT_EN
        else if (cnt_d == 16'(TIMEOUT_CYC)) begin
          state_d   = S_RESP;
          res_d     = '0;
          res_id_d  = grant_q;
          res_err_d = 1'b1;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      res_id_q     <= 2'd0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      res_q        <= '0;
      res_err_q    <= 1'b0;
      first_q      <= 1'b0;
`ifdef MUL_TIMEOUT_EN
      cnt_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      res_id_q     <= res_id_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      res_q        <= res_d;
      res_err_q    <= res_err_d;
      first_q      <= first_d;
`ifdef MUL_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mul_run   = (state_q == S_RUN);
  assign res_valid = (state_q == S_RESP);
  assign res_id    = res_id_q;
  assign res       = res_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
`ifdef MUL_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
  logic unused_err;
  assign unused_err = res_err_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed testbench for mul_arbiter with a behavioural multiplier stub.
// Define MUL_TIMEOUT_EN to also exercise the timeout abort path.
module tb_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [767:0] req_a, req_b;
  logic         res_valid, res_err, busy, mul_run, mul_done;
  logic [1:0]   res_id;
  logic [511:0] res, mul_c;
  logic [255:0] mul_a, mul_b;

  logic         force_done, never_done;
  logic [3:0]   stub_cnt;
  logic [511:0] prod;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef MUL_TIMEOUT_EN
  mul_arbiter #(.TIMEOUT_CYC(16)) dut (
`else
  mul_arbiter dut (
`endif
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_id(res_id), .res(res), .res_err(res_err),
    .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_run(mul_run),
    .mul_done(mul_done), .mul_c(mul_c)
  );

  // Multiplier stub: cleared while mul_run is low, done after 4 RUN cycles.
  always_ff @(posedge clk) begin
    if (!mul_run) stub_cnt <= 4'd0;
    else if (stub_cnt != 4'hf) stub_cnt <= stub_cnt + 4'd1;
  end
  assign prod     = {256'd0, mul_a} * {256'd0, mul_b};
  assign mul_done = force_done | (!never_done && mul_run && stub_cnt >= 4'd3);
  assign mul_c    = mul_done ? prod : '0;

  typedef struct {
    int           k;
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_resp(input int max, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (res_valid) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_resp: got no res_valid within %0d cycles expected one", max);
    end
  endtask

  task automatic wait_run(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (mul_run) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_run: got no mul_run within %0d cycles expected one", max);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_op(input int k, input logic [255:0] a, input logic [255:0] b);
    req_a[256*k +: 256] = a;
    req_b[256*k +: 256] = b;
  endtask

  initial begin
    int          cyc;
    bit          ok;
    logic [511:0] exp_ones;
    logic [511:0] exp_seq [3];

    rst = 1'b1; req = 3'b000; req_a = '0; req_b = '0;
    force_done = 1'b0; never_done = 1'b0;
    exp_ones = '0 - (512'd1 << 257) + 512'd1;

    vecs[0] = '{0, 256'd3, 256'd5, 512'd15};
    vecs[1] = '{1, 256'd1 << 32, 256'd1 << 32, 512'd1 << 64};
    vecs[2] = '{2, 256'd1 << 255, 256'd2, 512'd1 << 256};
    vecs[3] = '{0, {256{1'b1}}, {256{1'b1}}, exp_ones};
    vecs[4] = '{1, 256'hFFFF_FFFF, 256'h1_0000_0001, 512'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{2, 256'd0, 256'hDEAD_BEEF, 512'd0};

    #2;
    check("rst_busy", 512'(busy), 512'd0);
    check("rst_valid", 512'(res_valid), 512'd0);
    check("rst_run", 512'(mul_run), 512'd0);
    check("rst_res", res, 512'd0);
    check("rst_mul_a", 512'(mul_a), 512'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single-requester vectors, other operand slices filled with noise.
    foreach (vecs[v]) begin
      for (int s = 0; s < 24; s++) begin
        req_a[32*s +: 32] = $urandom;
        req_b[32*s +: 32] = $urandom;
      end
      set_op(vecs[v].k, vecs[v].a, vecs[v].b);
      req = 3'(1 << vecs[v].k);
      wait_resp(40, cyc, ok);
      $display("vec %0d: k=%0d res_id=%0d res=%0h", v, vecs[v].k, res_id, res);
      check("vec_res", res, vecs[v].exp);
      check("vec_id", 512'(res_id), 512'(vecs[v].k));
      check("vec_err", 512'(res_err), 512'd0);
      req = 3'b000;
      tick();
      check("vec_res_hold", res, vecs[v].exp);
      check("vec_valid_pulse", 512'(res_valid), 512'd0);
    end

    // All three requesting: served 0,1,2 with a single idle cycle between.
    do_reset();
    for (int k = 0; k < 3; k++) set_op(k, 256'(k + 2), 256'd7);
    exp_seq[0] = 512'd14; exp_seq[1] = 512'd21; exp_seq[2] = 512'd28;
    req = 3'b111;
    for (int j = 0; j < 3; j++) begin
      wait_resp(40, cyc, ok);
      $display("rr %0d: res_id=%0d res=%0d", j, res_id, res);
      check("rr_id", 512'(res_id), 512'(j));
      check("rr_res", res, exp_seq[j]);
      if (j < 2) begin
        tick();
        check("rr_gap_low", 512'(busy), 512'd0);
        tick();
        check("rr_gap_high", 512'(busy), 512'd1);
      end
    end
    req = 3'b000;
    tick();

    // Requester 1 re-requests while 2 is pending: order 1, 2, 1.
    do_reset();
    set_op(1, 256'd10, 256'd11);
    set_op(2, 256'd12, 256'd13);
    req = 3'b110;
    wait_resp(40, cyc, ok);
    $display("rerq 0: res_id=%0d res=%0d", res_id, res);
    check("rerq_id0", 512'(res_id), 512'd1);
    check("rerq_res0", res, 512'd110);
    req = 3'b100;
    tick();
    req = 3'b110;
    wait_resp(40, cyc, ok);
    $display("rerq 1: res_id=%0d res=%0d", res_id, res);
    check("rerq_id1", 512'(res_id), 512'd2);
    check("rerq_res1", res, 512'd156);
    req = 3'b010;
    wait_resp(40, cyc, ok);
    $display("rerq 2: res_id=%0d res=%0d", res_id, res);
    check("rerq_id2", 512'(res_id), 512'd1);
    check("rerq_res2", res, 512'd110);
    req = 3'b000;
    tick();

    // Reset pulse during RUN aborts, then the held request is re-served.
    set_op(1, 256'd6, 256'd9);
    req = 3'b010;
    wait_run(10);
    check("mr_mul_a", 512'(mul_a), 512'd6);
    tick();
    rst = 1'b1;
    #1;
    $display("midrst: busy=%0d run=%0d valid=%0d res=%0h", busy, mul_run, res_valid, res);
    check("mr_busy", 512'(busy), 512'd0);
    check("mr_run", 512'(mul_run), 512'd0);
    check("mr_valid", 512'(res_valid), 512'd0);
    check("mr_res", res, 512'd0);
    check("mr_id", 512'(res_id), 512'd0);
    check("mr_mul_a0", 512'(mul_a), 512'd0);
    tick();
    rst = 1'b0;
    wait_resp(40, cyc, ok);
    $display("midrst resume: res_id=%0d res=%0d", res_id, res);
    check("mr_id_after", 512'(res_id), 512'd1);
    check("mr_res_after", res, 512'd54);
    req = 3'b000;
    tick();

    // Done held high from the start: first RUN cycle must be ignored.
    force_done = 1'b1;
    set_op(0, 256'd3, 256'd5);
    req = 3'b001;
    wait_resp(20, cyc, ok);
    $display("early_done: cycles=%0d res=%0d", cyc, res);
    check("early_done_lat", 512'(cyc), 512'd4);
    check("early_done_res", res, 512'd15);
    force_done = 1'b0;
    req = 3'b000;
    tick();

`ifdef MUL_TIMEOUT_EN
    never_done = 1'b1;
    set_op(0, 256'd3, 256'd5);
    req = 3'b001;
    wait_run(10);
    wait_resp(40, cyc, ok);
    $display("timeout: cycles=%0d res=%0h err=%0d", cyc, res, res_err);
    check("to_lat", 512'(cyc), 512'd16);
    check("to_res", res, 512'd0);
    check("to_err", 512'(res_err), 512'd1);
    req = 3'b000;
    never_done = 1'b0;
    tick();
    req = 3'b001;
    wait_resp(40, cyc, ok);
    $display("after timeout: res=%0d err=%0d", res, res_err);
    check("to_next_res", res, 512'd15);
    check("to_next_err", 512'(res_err), 512'd0);
    req = 3'b000;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
    $fatal(1, "watchdog");
  end

endmodule
